// File: rtl/prco_debug_trace.sv
// prco_debug_trace: trace capture for the prco core debug port.
//
// Samples i_debug once per rising edge of the instruction strobe into a
// circular buffer of DEPTH entries, each tagged with a TS_W-bit timestamp.
// Capture runs pre-trigger, fires on the selected trigger, takes a fixed
// number of post-trigger samples, then freezes for oldest-first readback.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_en                    capture enable (masks sample events only)
//   i_arm                   one-cycle pulse: clear buffer, start capture
//   i_trig_mode             0 immediate, 1 value match, 2 external, 3 never
//   i_trig_value            match value for mode 1
//   i_trig_ext              external trigger for mode 2
//   i_post_count            samples after the trigger sample (clamped DEPTH-1)
//   i_instr_clk, i_debug    core instruction strobe and debug bus
//   i_rd_req                read request (honoured in DONE only)
//   q_rd_valid, q_rd_data   read response {timestamp, sample}, one cycle later
//   q_state                 0 IDLE, 1 PRE, 2 POST, 3 DONE
//   q_count                 valid entries, 0..DEPTH
//   q_overrun               pre-trigger data was overwritten
//
// state | meaning
// IDLE  | after reset, nothing captured
// PRE   | capturing, waiting for trigger
// POST  | trigger seen, taking remaining post-trigger samples
// DONE  | buffer frozen, readback allowed
module prco_debug_trace #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_en,
    input  logic                   i_arm,
    input  logic [1:0]             i_trig_mode,
    input  logic [DATA_W-1:0]      i_trig_value,
    input  logic                   i_trig_ext,
    input  logic [ADDR_W:0]        i_post_count,
    input  logic                   i_instr_clk,
    input  logic [DATA_W-1:0]      i_debug,
    input  logic                   i_rd_req,
    output logic                   q_rd_valid,
    output logic [TS_W+DATA_W-1:0] q_rd_data,
    output logic [1:0]             q_state,
    output logic [ADDR_W:0]        q_count,
    output logic                   q_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_MAXP = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [TS_W-1:0]   TS_ONE   = 1;

    state_t                   state, state_d;
    logic [TS_W+DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        rd_idx;
    logic [ADDR_W:0]          count;
    logic [ADDR_W:0]          post_rem;
    logic [TS_W-1:0]          ts;
    logic [1:0]               mode_q;
    logic [DATA_W-1:0]        value_q;
    logic                     instr_q;
    logic                     overrun;
    logic                     sample;
    logic                     trig_hit;
    logic                     do_write;
    logic                     do_read;

    // History resets high so a strobe already high at reset release is not an edge.
    assign sample = i_instr_clk & ~instr_q & i_en;
    assign rd_idx = wr_ptr - count[ADDR_W-1:0];

    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            2'd0:    trig_hit = 1'b1;
            2'd1:    trig_hit = (i_debug == value_q);
            2'd2:    trig_hit = i_trig_ext;
            default: trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state;
        do_write = 1'b0;
        do_read  = 1'b0;
        case (state)
            PRE: begin
                if (sample) begin
                    do_write = 1'b1;
                    if (trig_hit)
                        state_d = (post_rem == '0) ? DONE : POST;
                end
            end
            POST: begin
                if (sample) begin
                    do_write = 1'b1;
                    if (post_rem == CNT_ONE)
                        state_d = DONE;
                end
            end
            DONE: begin
                do_read = i_rd_req && (count != '0);
            end
            default: ;
        endcase
        if (i_arm) begin
            state_d  = PRE;
            do_write = 1'b0;
            do_read  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            count      <= '0;
            post_rem   <= '0;
            ts         <= '0;
            mode_q     <= '0;
            value_q    <= '0;
            instr_q    <= 1'b1;
            overrun    <= 1'b0;
            q_rd_valid <= 1'b0;
            q_rd_data  <= '0;
        end else begin
            instr_q    <= i_instr_clk;
            q_rd_valid <= 1'b0;
            if (i_arm) begin
                wr_ptr   <= '0;
                count    <= '0;
                ts       <= '0;
                overrun  <= 1'b0;
                mode_q   <= i_trig_mode;
                value_q  <= i_trig_value;
                post_rem <= (i_post_count > CNT_MAXP) ? CNT_MAXP : i_post_count;
            end else begin
                if (state == PRE || state == POST)
                    ts <= ts + TS_ONE;
                if (do_write) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    if (count == CNT_FULL)
                        overrun <= 1'b1;
                    else
                        count <= count + CNT_ONE;
                end
                if (state == POST && sample)
                    post_rem <= post_rem - CNT_ONE;
                if (do_read) begin
                    q_rd_valid <= 1'b1;
                    q_rd_data  <= mem[rd_idx];
                    count      <= count - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_write && !i_reset)
            mem[wr_ptr] <= {ts, i_debug};
    end

    assign q_state   = state;
    assign q_count   = count;
    assign q_overrun = overrun;

endmodule

// File: tb/tb_prco_debug_trace.sv
module tb_prco_debug_trace;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int TS_W   = 16;

    logic                   clk = 1'b0;
    logic                   i_reset;
    logic                   i_en;
    logic                   i_arm;
    logic [1:0]             i_trig_mode;
    logic [DATA_W-1:0]      i_trig_value;
    logic                   i_trig_ext;
    logic [ADDR_W:0]        i_post_count;
    logic                   i_instr_clk;
    logic [DATA_W-1:0]      i_debug;
    logic                   i_rd_req;
    logic                   q_rd_valid;
    logic [TS_W+DATA_W-1:0] q_rd_data;
    logic [1:0]             q_state;
    logic [ADDR_W:0]        q_count;
    logic                   q_overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] e [16];

    always #5 clk = ~clk;

    prco_debug_trace #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_en(i_en),
        .i_arm(i_arm),
        .i_trig_mode(i_trig_mode),
        .i_trig_value(i_trig_value),
        .i_trig_ext(i_trig_ext),
        .i_post_count(i_post_count),
        .i_instr_clk(i_instr_clk),
        .i_debug(i_debug),
        .i_rd_req(i_rd_req),
        .q_rd_valid(q_rd_valid),
        .q_rd_data(q_rd_data),
        .q_state(q_state),
        .q_count(q_count),
        .q_overrun(q_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [7:0] val, input logic [4:0] post);
        i_trig_mode  = mode;
        i_trig_value = val;
        i_post_count = post;
        i_arm        = 1'b1;
        @(negedge clk);
        i_arm        = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v, input logic ext);
        i_debug     = v;
        i_trig_ext  = ext;
        i_instr_clk = 1'b1;
        @(negedge clk);
        i_instr_clk = 1'b0;
        i_trig_ext  = 1'b0;
        @(negedge clk);
    endtask

    // Back-to-back reads, checking data and strictly increasing timestamps.
    task automatic read_burst(input string tag, input int n);
        logic [15:0] prev_ts;
        prev_ts  = '0;
        i_rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) i_rd_req = 1'b0;
            chk({tag, "_valid"}, {31'd0, q_rd_valid}, 32'd1);
            chk({tag, "_data"}, {24'd0, q_rd_data[7:0]}, {24'd0, e[i]});
            if (i > 0)
                chk({tag, "_ts_inc"}, {31'd0, (q_rd_data[23:8] > prev_ts)}, 32'd1);
            prev_ts = q_rd_data[23:8];
        end
    endtask

    task automatic read_none(input string tag);
        i_rd_req = 1'b1;
        @(negedge clk);
        i_rd_req = 1'b0;
        chk(tag, {31'd0, q_rd_valid}, 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_en = 1'b1; i_arm = 1'b0; i_trig_mode = 2'd0;
        i_trig_value = '0; i_trig_ext = 1'b0; i_post_count = '0;
        i_instr_clk = 1'b1; i_debug = 8'hEE; i_rd_req = 1'b0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_state", {30'd0, q_state}, 32'd0);
        chk("rst_count", {27'd0, q_count}, 32'd0);
        chk("rst_overrun", {31'd0, q_overrun}, 32'd0);
        chk("rst_valid", {31'd0, q_rd_valid}, 32'd0);
        chk("rst_data", q_rd_data, 32'd0);
        // Strobe still high: arming must not see an edge.
        do_arm(2'd0, 8'h00, 5'd3);
        repeat (2) @(negedge clk);
        chk("held_strobe_count", {27'd0, q_count}, 32'd0);
        chk("held_strobe_state", {30'd0, q_state}, 32'd1);
        i_instr_clk = 1'b0;
        @(negedge clk);

        // Mode 0, post 3
        do_arm(2'd0, 8'h00, 5'd3);
        for (int i = 0; i < 3; i++) strobe(8'h10 + 8'(i), 1'b0);
        chk("m0_state_post", {30'd0, q_state}, 32'd2);
        strobe(8'h13, 1'b0);
        chk("m0_state_done", {30'd0, q_state}, 32'd3);
        strobe(8'h14, 1'b0);
        chk("m0_count", {27'd0, q_count}, 32'd4);
        chk("m0_overrun", {31'd0, q_overrun}, 32'd0);
        for (int i = 0; i < 4; i++) e[i] = 8'h10 + 8'(i);
        read_burst("m0_rd", 4);
        read_none("m0_rd5");
        chk("m0_count_empty", {27'd0, q_count}, 32'd0);

        // Mode 1, match A5, post 2
        do_arm(2'd1, 8'hA5, 5'd2);
        for (int i = 0; i < 20; i++) strobe(8'(i), 1'b0);
        chk("m1_pre_state", {30'd0, q_state}, 32'd1);
        strobe(8'hA5, 1'b0);
        strobe(8'h30, 1'b0);
        strobe(8'h31, 1'b0);
        chk("m1_state", {30'd0, q_state}, 32'd3);
        chk("m1_count", {27'd0, q_count}, 32'd16);
        chk("m1_overrun", {31'd0, q_overrun}, 32'd1);
        for (int i = 0; i < 13; i++) e[i] = 8'h07 + 8'(i);
        e[13] = 8'hA5; e[14] = 8'h30; e[15] = 8'h31;
        read_burst("m1_rd", 16);

        // Mode 2, post 1, enable masking
        do_arm(2'd2, 8'h00, 5'd1);
        chk("m2_overrun_clr", {31'd0, q_overrun}, 32'd0);
        i_en = 1'b0;
        strobe(8'h77, 1'b1);
        strobe(8'h78, 1'b1);
        chk("m2_en_state", {30'd0, q_state}, 32'd1);
        chk("m2_en_count", {27'd0, q_count}, 32'd0);
        i_en = 1'b1;
        strobe(8'h40, 1'b0);
        chk("m2_noext_state", {30'd0, q_state}, 32'd1);
        strobe(8'h41, 1'b1);
        strobe(8'h42, 1'b0);
        chk("m2_state", {30'd0, q_state}, 32'd3);
        chk("m2_count", {27'd0, q_count}, 32'd3);
        e[0] = 8'h40; e[1] = 8'h41; e[2] = 8'h42;
        read_burst("m2_rd", 3);

        // Mode 0, post 20 clamped to 15
        do_arm(2'd0, 8'h00, 5'd20);
        for (int i = 0; i < 15; i++) strobe(8'(i), 1'b0);
        chk("clamp_state_post", {30'd0, q_state}, 32'd2);
        strobe(8'h0F, 1'b0);
        chk("clamp_state_done", {30'd0, q_state}, 32'd3);
        strobe(8'h10, 1'b0);
        chk("clamp_count", {27'd0, q_count}, 32'd16);
        chk("clamp_overrun", {31'd0, q_overrun}, 32'd0);
        for (int i = 0; i < 16; i++) e[i] = 8'(i);
        read_burst("clamp_rd", 16);

        // Reset during POST
        do_arm(2'd0, 8'h00, 5'd5);
        strobe(8'h60, 1'b0);
        strobe(8'h61, 1'b0);
        chk("rst_mid_post", {30'd0, q_state}, 32'd2);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst_mid_state", {30'd0, q_state}, 32'd0);
        chk("rst_mid_count", {27'd0, q_count}, 32'd0);
        read_none("rst_mid_rd");

        // Arm beats read in DONE
        do_arm(2'd0, 8'h00, 5'd0);
        strobe(8'h55, 1'b0);
        chk("armrd_done", {30'd0, q_state}, 32'd3);
        chk("armrd_count1", {27'd0, q_count}, 32'd1);
        i_arm = 1'b1; i_rd_req = 1'b1;
        @(negedge clk);
        i_arm = 1'b0; i_rd_req = 1'b0;
        chk("armrd_state", {30'd0, q_state}, 32'd1);
        chk("armrd_count", {27'd0, q_count}, 32'd0);
        chk("armrd_valid", {31'd0, q_rd_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
